// File: rtl/note_write_sequencer_pkg.sv
// Shared note-memory package: write FSM state encoding and the default
// geometry reused by the note RAM, the write sequencer and the playback reader.
package note_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    WRITE = 2'd2
  } wr_state_e;

  localparam int NOTE_ADDR_W  = 6;   // pointer width per track
  localparam int NOTE_DEPTH   = 64;  // notes per track
  localparam int NOTE_TRACK_W = 1;   // track select width

  // Number of tracks addressed by a track select of width tw.
  function automatic int tracks_of(input int tw);
    return 1 << tw;
  endfunction

endpackage

// File: rtl/note_write_sequencer_if.sv
// Record-control <-> write-sequencer bus. The master modport is the
// keyboard/record control side; the slave modport is the sequencer.
interface note_write_sequencer_if
  import note_mem_pkg::*;
#(
  parameter int ADDR_W  = NOTE_ADDR_W,
  parameter int TRACK_W = NOTE_TRACK_W
);
  logic                      mem_enable;
  logic                      write;
  logic [TRACK_W-1:0]        track_sel;
  logic                      clear_track;
  logic                      wrap_mode;
  logic                      WE;
  logic [TRACK_W+ADDR_W-1:0] writeAddress;
  logic [ADDR_W:0]           track_length;
  logic                      full;
  logic                      busy;
  logic                      overflow;

  modport master (
    output mem_enable, write, track_sel, clear_track, wrap_mode,
    input  WE, writeAddress, track_length, full, busy, overflow
  );

  modport slave (
    input  mem_enable, write, track_sel, clear_track, wrap_mode,
    output WE, writeAddress, track_length, full, busy, overflow
  );
endinterface

// File: rtl/note_write_sequencer_edge.sv
// write_edge_detect: qualified rising-edge detector. The level history is
// registered every cycle regardless of qualify, so a level held high across
// a qualify change never produces a late pulse. Also used for play/stop keys.
module write_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  input  logic qualify,
  output logic pulse
);
  logic level_q;

  // One-cycle history of the level input.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign pulse = level & qualify & ~level_q;
endmodule

// File: rtl/note_write_sequencer.sv
// note_write_sequencer: turns a key-press write strobe into one WE pulse with a
// track-qualified address, keeping a per-track pointer and note count.
// Request edge at clock n -> ARM after n -> WE in the cycle after n+1.
// Optional: `define NOTE_WR_OVERFLOW_EN for the sticky overflow flag.
// DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_W.
module note_write_sequencer
  import note_mem_pkg::*;
#(
  parameter int ADDR_W  = NOTE_ADDR_W,
  parameter int DEPTH   = NOTE_DEPTH,
  parameter int TRACK_W = NOTE_TRACK_W
) (
  input  logic                  clock,
  input  logic                  reset,
  note_write_sequencer_if.slave bus
);
  localparam int                TRACKS   = tracks_of(TRACK_W);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

  wr_state_e                        state;
  logic [TRACK_W-1:0]               trk;
  logic [TRACKS-1:0][ADDR_W-1:0]    ptr;
  logic [TRACKS-1:0][ADDR_W:0]      cnt;
  logic                             we_r;
  logic                             busy_r;
  logic [TRACK_W+ADDR_W-1:0]        waddr_r;
  logic                             req;
  logic                             hit_trk;
  logic                             abort;
  logic                             reject;
  logic                             commit;

  write_edge_detect u_edge (
    .clock   (clock),
    .reset   (reset),
    .level   (bus.write),
    .qualify (bus.mem_enable),
    .pulse   (req)
  );

  // A clear aimed at the in-flight track kills that write, even in WRITE:
  // WE is masked combinationally so the RAM never sees the aborted slot.
  assign hit_trk = bus.clear_track & (bus.track_sel == trk);
  assign abort   = (state != IDLE) & hit_trk;
  assign reject  = (state == ARM) & ~abort & (cnt[trk] == CNT_FULL) & ~bus.wrap_mode;
  assign commit  = (state == WRITE) & ~abort;

  // Control FSM: accept request, qualify against fullness, issue one WE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      trk     <= '0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      waddr_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          // clear_track wins; a coincident request is dropped.
          if (!bus.clear_track && req) begin
            trk    <= bus.track_sel;
            state  <= ARM;
            busy_r <= 1'b1;
          end
        end
        ARM: begin
          // wrap_mode is looked at here, not at request time.
          if (abort || reject) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            state   <= WRITE;
            we_r    <= 1'b1;
            waddr_r <= {trk, ptr[trk]};
          end
        end
        WRITE: begin
          state  <= IDLE;
          we_r   <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          we_r   <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Per-track pointer/count: clear has priority, then the committed write
  // advances modulo DEPTH and the count saturates at DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      for (int t = 0; t < TRACKS; t++) begin
        if (bus.clear_track && bus.track_sel == TRACK_W'(t)) begin
          ptr[t] <= '0;
          cnt[t] <= '0;
        end else if (commit && trk == TRACK_W'(t)) begin
          ptr[t] <= (ptr[t] == PTR_LAST) ? '0 : ptr[t] + 1'b1;
          if (cnt[t] != CNT_FULL) cnt[t] <= cnt[t] + 1'b1;
        end
      end
    end
  end

  assign bus.WE           = we_r & ~abort;
  assign bus.writeAddress = waddr_r;
  assign bus.track_length = cnt[bus.track_sel];
  assign bus.full         = (cnt[bus.track_sel] == CNT_FULL);
  assign bus.busy         = busy_r;

`ifdef NOTE_WR_OVERFLOW_EN
  logic               ovf_r;
  logic [TRACK_W-1:0] ovf_trk;

  // Sticky overflow: a new rejection wins over a same-cycle clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_r   <= 1'b0;
      ovf_trk <= '0;
    end else if (reject) begin
      ovf_r   <= 1'b1;
      ovf_trk <= trk;
    end else if (bus.clear_track && bus.track_sel == ovf_trk) begin
      ovf_r   <= 1'b0;
    end
  end

  assign bus.overflow = ovf_r;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_note_write_sequencer.sv
// Bench for note_write_sequencer: transaction-level model (request age,
// per-track pointer/count arrays) checked every negedge, plus directed
// literal expectations on the captured WE address log.
module tb_note_write_sequencer;
  localparam int AW = 6;
  localparam int DP = 64;
  localparam int TW = 1;
  localparam int NT = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  note_write_sequencer_if #(.ADDR_W(AW), .TRACK_W(TW)) bus ();

  note_write_sequencer #(.ADDR_W(AW), .DEPTH(DP), .TRACK_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int nvec  = 0;
  int nfail = 0;
  int we_log[$];

  // Model state
  int m_cnt[NT] = '{0, 0};
  int m_ptr[NT] = '{0, 0};
  bit m_inflight = 0;
  int m_age = 0;
  int m_ftrk = 0;
  bit m_hist = 0;
  bit m_ovf = 0;
  int m_ovf_trk = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request lives for two cycles after acceptance; at age 1 it is
  // checked against fullness, at age 2 it is the write cycle.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cnt = '{0, 0}; m_ptr = '{0, 0};
      m_inflight = 0; m_age = 0; m_ftrk = 0; m_hist = 0;
      m_ovf = 0; m_ovf_trk = 0;
    end else begin
      bit req, clr;
      int s;
      req = bus.write && bus.mem_enable && !m_hist;
      m_hist = bus.write;
      clr = bus.clear_track;
      s = int'(bus.track_sel);
      if (clr && s == m_ovf_trk) m_ovf = 0;
      if (m_inflight && m_age == 2) begin
        if (!(clr && s == m_ftrk)) begin
          m_ptr[m_ftrk] = (m_ptr[m_ftrk] + 1) % DP;
          if (m_cnt[m_ftrk] < DP) m_cnt[m_ftrk]++;
        end
        m_inflight = 0;
      end else if (m_inflight && m_age == 1) begin
        if (clr && s == m_ftrk) m_inflight = 0;
        else if (m_cnt[m_ftrk] == DP && !bus.wrap_mode) begin
          m_inflight = 0; m_ovf = 1; m_ovf_trk = m_ftrk;
        end else m_age = 2;
      end else if (!m_inflight && !clr && req) begin
        m_inflight = 1; m_age = 1; m_ftrk = s;
      end
      if (clr) begin m_cnt[s] = 0; m_ptr[s] = 0; end
    end
  end

  // Compare process: every negedge.
  always @(negedge clock) begin
    bit exp_we;
    int sel;
    sel = int'(bus.track_sel);
    exp_we = m_inflight && m_age == 2 && !(bus.clear_track && sel == m_ftrk);
    chk("WE", int'(bus.WE), int'(exp_we));
    if (exp_we) chk("writeAddress", int'(bus.writeAddress), m_ftrk * (1 << AW) + m_ptr[m_ftrk]);
    chk("busy", int'(bus.busy), int'(m_inflight));
    chk("track_length", int'(bus.track_length), m_cnt[sel]);
    chk("full", int'(bus.full), int'(m_cnt[sel] == DP));
`ifdef NOTE_WR_OVERFLOW_EN
    chk("overflow", int'(bus.overflow), int'(m_ovf));
`else
    chk("overflow", int'(bus.overflow), 0);
`endif
    if (bus.WE) we_log.push_back(int'(bus.writeAddress));
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_write(input int t);
    bus.track_sel = 1'(t);
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_clear(input int t);
    bus.track_sel = 1'(t);
    bus.clear_track = 1'b1;
    tick();
    bus.clear_track = 1'b0;
    tick();
  endtask

  initial begin
    int bad;
    bus.mem_enable = 1'b0; bus.write = 1'b0; bus.track_sel = '0;
    bus.clear_track = 1'b0; bus.wrap_mode = 1'b0;
    repeat (3) tick();
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_addr", int'(bus.writeAddress), 0);
    reset = 1'b1;
    tick();

    // Basic write with latency pin and held strobe
    bus.mem_enable = 1'b1; bus.track_sel = 1'b0; bus.write = 1'b1;
    tick();
    chk("lat_arm_we", int'(bus.WE), 0);
    tick();
    chk("lat_we", int'(bus.WE), 1);
    chk("lat_addr", int'(bus.writeAddress), 0);
    tick();
    chk("basic_len", int'(bus.track_length), 1);
    repeat (5) tick();
    chk("held_one_we", we_log.size(), 1);
    bus.write = 1'b0;
    tick();

    // Stop mode, track 1 fills and rejects the 65th
    we_log.delete();
    bus.wrap_mode = 1'b0;
    for (int i = 0; i < 65; i++) do_write(1);
    chk("stop_we_count", we_log.size(), 64);
    bad = 0;
    for (int i = 0; i < we_log.size(); i++) if (we_log[i] != 64 + i) bad++;
    chk("stop_addrs_bad", bad, 0);
    chk("stop_full", int'(bus.full), 1);
    chk("stop_len", int'(bus.track_length), 64);
`ifdef NOTE_WR_OVERFLOW_EN
    chk("stop_ovf", int'(bus.overflow), 1);
`else
    chk("stop_ovf", int'(bus.overflow), 0);
`endif
    pulse_clear(1);
    chk("ovf_cleared", int'(bus.overflow), 0);

    // Wrap mode, track 0 from empty
    pulse_clear(0);
    we_log.delete();
    bus.wrap_mode = 1'b1;
    for (int i = 0; i < 66; i++) do_write(0);
    chk("wrap_we_count", we_log.size(), 66);
    chk("wrap_65th", we_log[64], 0);
    chk("wrap_66th", we_log[65], 1);
    chk("wrap_len", int'(bus.track_length), 64);
    chk("wrap_ovf", int'(bus.overflow), 0);

    // Clear collisions
    pulse_clear(0);
    pulse_clear(1);
    we_log.delete();
    bus.track_sel = 1'b0; bus.write = 1'b1; bus.clear_track = 1'b1;
    tick();
    bus.write = 1'b0; bus.clear_track = 1'b0;
    tick(); tick();
    chk("clr_same_cycle_we", we_log.size(), 0);
    do_write(0); do_write(0);
    bus.track_sel = 1'b0; bus.write = 1'b1;
    tick();
    bus.write = 1'b0; bus.clear_track = 1'b1;
    tick();
    bus.clear_track = 1'b0;
    tick(); tick();
    chk("clr_arm_we_count", we_log.size(), 2);
    chk("clr_arm_len", int'(bus.track_length), 0);
    do_write(0);
    chk("clr_arm_ptr0", we_log[$], 0);
    do_write(1); do_write(1);
    bus.track_sel = 1'b0; bus.write = 1'b1;
    tick();
    bus.write = 1'b0; bus.track_sel = 1'b1; bus.clear_track = 1'b1;
    tick();
    bus.clear_track = 1'b0; bus.track_sel = 1'b0;
    chk("clr_other_we", int'(bus.WE), 1);
    chk("clr_other_addr", int'(bus.writeAddress), 1);
    tick();
    chk("clr_other_len0", int'(bus.track_length), 2);
    bus.track_sel = 1'b1;
    #1;
    chk("clr_other_len1", int'(bus.track_length), 0);
    tick();

    // mem_enable low blocks requests
    we_log.delete();
    bus.mem_enable = 1'b0; bus.track_sel = 1'b0; bus.write = 1'b1;
    repeat (4) tick();
    bus.write = 1'b0;
    tick();
    bus.mem_enable = 1'b1;
    tick();
    chk("men_off_we", we_log.size(), 0);

    // Async reset in the middle of WRITE
    bus.track_sel = 1'b0; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    tick();
    chk("mid_we_before", int'(bus.WE), 1);
    #1; reset = 1'b0; #1;
    chk("mid_we_after", int'(bus.WE), 0);
    chk("mid_busy_after", int'(bus.busy), 0);
    chk("mid_len0", int'(bus.track_length), 0);
    bus.track_sel = 1'b1; #1;
    chk("mid_len1", int'(bus.track_length), 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Independent tracks
    we_log.delete();
    do_write(0); do_write(1); do_write(0); do_write(1); do_write(0);
    chk("ind_count", we_log.size(), 5);
    bad = 0;
    begin
      int exp_addr[5];
      exp_addr = '{0, 64, 1, 65, 2};
      for (int i = 0; i < 5 && i < we_log.size(); i++) if (we_log[i] != exp_addr[i]) bad++;
    end
    chk("ind_addrs_bad", bad, 0);
    bus.track_sel = 1'b0; #1;
    chk("ind_len0", int'(bus.track_length), 3);
    bus.track_sel = 1'b1; #1;
    chk("ind_len1", int'(bus.track_length), 2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
